bcd_to_binary_seq: RTL and testbench

Sequential BCD-to-binary converter. It is the inverse companion of the team's binary-to-BCD converter. It accepts a packed multi-digit BCD word on a single-cycle load strobe and produces the equivalent unsigned binary value with a single-cycle done strobe (enaOut). It uses an iterative multiply-by-10-and-add datapath that consumes one digit per clock, most-significant digit first. It sits on the display/host side of the design, where decimal operands are converted back to binary.

---
 rtl/bcd_to_binary_seq.sv | 100 ++++++++++
 tb/tb_bcd_to_binary_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with sticky overflow and invalid-digit flags.
module bcd_to_binary_seq #(
   parameter int binaryNumberWidth = 32,
   parameter int numberOfDigits    = 6
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                load,
   input  logic [numberOfDigits-1:0][3:0]      BinaryDecimal,
   output logic [binaryNumberWidth-1:0]        binaryNumber,
   output logic                                enaOut,
   output logic                                busy,
   output logic                                overflow,
   output logic                                invalidDigit
);

   localparam int W  = binaryNumberWidth;
   localparam int N  = numberOfDigits;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t           state, state_next;
   logic [4*N-1:0]   shreg;
   logic [W-1:0]     acc;
   logic [CW-1:0]    cnt;
   logic             ovf_s, inv_s;

   logic [3:0]       digit;
   logic [W+3:0]     full;
   logic             last, accept, ovf_now, inv_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      digit      = shreg[4*N-1 -: 4];
      // acc*10 as (acc<<3)+(acc<<1); four extra bits catch any carry out of W
      full       = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{W{1'b0}}, digit};
      last       = (cnt == '0);
      ovf_now    = ovf_s | (|full[W+3:W]);
      inv_now    = inv_s | (digit > 4'd9);
      case (state)
         IDLE: begin
            if (load) begin
               accept     = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            if (last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == CONV);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg        <= '0;
         acc          <= '0;
         cnt          <= '0;
         ovf_s        <= 1'b0;
         inv_s        <= 1'b0;
         binaryNumber <= '0;
         overflow     <= 1'b0;
         invalidDigit <= 1'b0;
         enaOut       <= 1'b0;
      end else begin
         enaOut <= 1'b0;
         if (accept) begin
            shreg <= BinaryDecimal;
            acc   <= '0;
            cnt   <= CW'(N - 1);
            ovf_s <= 1'b0;
            inv_s <= 1'b0;
         end else if (state == CONV) begin
            acc   <= full[W-1:0];
            shreg <= shreg << 4;
            ovf_s <= ovf_now;
            inv_s <= inv_now;
            if (last) begin
               binaryNumber <= full[W-1:0];
               overflow     <= ovf_now;
               invalidDigit <= inv_now;
               enaOut       <= 1'b1;
            end else begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: default (W=32,N=6), narrow (W=16,N=6)
// and single-digit (W=8,N=1) instances sharing clock and reset.
module tb_bcd_to_binary_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic             load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
   logic [5:0][3:0]  bd_a = '0;
   logic [5:0][3:0]  bd_b = '0;
   logic [0:0][3:0]  bd_c = '0;

   logic [31:0] num_a;
   logic [15:0] num_b;
   logic [7:0]  num_c;
   logic ena_a, busy_a, ovf_a, inv_a;
   logic ena_b, busy_b, ovf_b, inv_b;
   logic ena_c, busy_c, ovf_c, inv_c;

   int compared   = 0;
   int mismatched = 0;
   int lat, bc, cnt_e, cnt_b;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(.binaryNumberWidth(32), .numberOfDigits(6)) dut_a (
      .clk(clk), .rst_n(rst_n), .load(load_a), .BinaryDecimal(bd_a),
      .binaryNumber(num_a), .enaOut(ena_a), .busy(busy_a),
      .overflow(ovf_a), .invalidDigit(inv_a));

   bcd_to_binary_seq #(.binaryNumberWidth(16), .numberOfDigits(6)) dut_b (
      .clk(clk), .rst_n(rst_n), .load(load_b), .BinaryDecimal(bd_b),
      .binaryNumber(num_b), .enaOut(ena_b), .busy(busy_b),
      .overflow(ovf_b), .invalidDigit(inv_b));

   bcd_to_binary_seq #(.binaryNumberWidth(8), .numberOfDigits(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .load(load_c), .BinaryDecimal(bd_c),
      .binaryNumber(num_c), .enaOut(ena_c), .busy(busy_c),
      .overflow(ovf_c), .invalidDigit(inv_c));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ena_of(input int w);
      case (w)
         0:       return ena_a;
         1:       return ena_b;
         default: return ena_c;
      endcase
   endfunction

   function automatic logic busy_of(input int w);
      case (w)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   // Entered at a negedge: drives load for one edge, returns at the next negedge.
   task automatic start(input int w, input logic [23:0] digits);
      case (w)
         0:       begin bd_a = digits; load_a = 1'b1; end
         1:       begin bd_b = digits; load_b = 1'b1; end
         default: begin bd_c = digits[3:0]; load_c = 1'b1; end
      endcase
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      load_c = 1'b0;
   endtask

   task automatic wait_done(input int w, output int l, output int b);
      l = 0;
      b = busy_of(w) ? 1 : 0;
      while (!ena_of(w) && l < 40) begin
         @(negedge clk);
         l++;
         if (busy_of(w)) b++;
      end
   endtask

   initial begin
      @(negedge clk);
      #1;
      check("reset_a", {num_a, ena_a, busy_a, ovf_a, inv_a}, 64'd0);
      check("reset_b", {num_b, ena_b, busy_b, ovf_b, inv_b}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 123456 on the default instance
      start(0, 24'h123456);
      check("hold_during_conv", num_a, 64'd0);
      check("busy_after_accept", busy_a, 64'd1);
      wait_done(0, lat, bc);
      check("latency_123456", lat, 64'd6);
      check("busy_cycles", bc, 64'd6);
      check("result_123456", num_a, 64'h1E240);
      check("ovf_123456", ovf_a, 64'd0);
      check("inv_123456", inv_a, 64'd0);
      @(negedge clk);
      check("ena_one_cycle", {ena_a, busy_a}, 64'd0);

      // 999999 then 000000 loaded in the enaOut cycle
      start(0, 24'h999999);
      wait_done(0, lat, bc);
      check("result_999999", num_a, 64'hF423F);
      start(0, 24'h000000);
      check("ena_deassert_b2b", ena_a, 64'd0);
      check("hold_b2b", num_a, 64'hF423F);
      wait_done(0, lat, bc);
      check("b2b_spacing", lat + 1, 64'd7);
      check("result_000000", num_a, 64'd0);

      // W=16 overflow and largest fitting value
      @(negedge clk);
      start(1, 24'h070000);
      wait_done(1, lat, bc);
      check("latency_w16", lat, 64'd6);
      check("result_70000_w16", num_b, 64'h1170);
      check("ovf_70000_w16", ovf_b, 64'd1);
      @(negedge clk);
      start(1, 24'h065535);
      wait_done(1, lat, bc);
      check("result_65535_w16", num_b, 64'hFFFF);
      check("ovf_65535_w16", ovf_b, 64'd0);

      // invalid digit A in the LSD: 1*10 + 10
      @(negedge clk);
      start(0, 24'h00001A);
      wait_done(0, lat, bc);
      check("result_invalid", num_a, 64'd20);
      check("inv_set", inv_a, 64'd1);
      @(negedge clk);
      start(0, 24'h123456);
      wait_done(0, lat, bc);
      check("inv_cleared", inv_a, 64'd0);
      check("result_after_inv", num_a, 64'h1E240);

      // load during CONV must be ignored
      @(negedge clk);
      start(0, 24'h123456);
      @(negedge clk);
      @(negedge clk);
      bd_a   = 24'h999999;
      load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      wait_done(0, lat, bc);
      check("ignored_load_latency", lat, 64'd3);
      check("ignored_load_result", num_a, 64'h1E240);
      cnt_e = 0;
      cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ena_a)  cnt_e++;
         if (busy_a) cnt_b++;
      end
      check("ignored_load_no_extra_ena", cnt_e, 64'd0);
      check("ignored_load_no_restart", cnt_b, 64'd0);

      // asynchronous reset mid-conversion
      start(0, 24'h999999);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_a", {num_a, ena_a, busy_a, ovf_a, inv_a}, 64'd0);
      check("async_reset_b", {num_b, ena_b, busy_b, ovf_b, inv_b}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_e = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ena_a) cnt_e++;
      end
      check("no_ena_after_abort", cnt_e, 64'd0);
      start(0, 24'h999999);
      wait_done(0, lat, bc);
      check("latency_after_reset", lat, 64'd6);
      check("result_after_reset", num_a, 64'hF423F);

      // single-digit instance
      @(negedge clk);
      start(2, 24'h000007);
      wait_done(2, lat, bc);
      check("latency_n1", lat, 64'd1);
      check("result_n1", {num_c, inv_c}, {56'd0, 8'd7, 1'b0} >> 1 << 1 | 64'd0);
      @(negedge clk);
      start(2, 24'h00000C);
      wait_done(2, lat, bc);
      check("result_n1_invalid", num_c, 64'd12);
      check("inv_n1", inv_c, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
